// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side buffer between uart_rx and the APB register block.
//
// Bytes pulsed in from uart_rx are stored in a first-word-fall-through FIFO
// drained over valid/ready. Also provides receive gating, a sticky overrun
// flag, a fill-level interrupt and an optional character-timeout interrupt.
//
// Optional feature macro: UART_RX_CTRL_TIMEOUT_EN builds the timeout FSM;
// when undefined timeout_irq_o is tied low and timeout_bits_i is ignored.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   rx_en_i                   receive enable (bytes discarded when 0)
//   flush_i                   one-cycle FIFO clear, wins over push/pop
//   rx_data_i, rx_valid_i     byte + one-cycle strobe from uart_rx
//   data_o, valid_o, ready_i  FIFO head, non-empty, consumer pop
//   count_o                   fill level 0..FifoDepth
//   threshold_i, thresh_irq_o fill interrupt (threshold 0 disables)
//   overrun_o, overrun_clr_i  sticky drop flag and its clear
//   timeout_bits_i            char timeout in bit periods (0 disables)
//   timeout_irq_o             char timeout interrupt
module uart_rx_ctrl #(
    parameter int  FifoDepth = 16,
    parameter int  BitTicks  = 8,
    localparam int CntW      = $clog2(FifoDepth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rx_en_i,
    input  logic            flush_i,
    input  logic [7:0]      rx_data_i,
    input  logic            rx_valid_i,
    output logic [7:0]      data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [CntW-1:0] count_o,
    input  logic [CntW-1:0] threshold_i,
    output logic            thresh_irq_o,
    output logic            overrun_o,
    input  logic            overrun_clr_i,
    input  logic [7:0]      timeout_bits_i,
    output logic            timeout_irq_o
);
    localparam int PtrW = $clog2(FifoDepth);

    logic [7:0]      mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            overrun_q;
    logic            full, pop, push_req, push, drop;

    assign valid_o  = (count_q != '0);
    assign full     = (count_q == CntW'(FifoDepth));
    assign pop      = valid_o && ready_i;
    assign push_req = rx_valid_i && rx_en_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        if (flush_i)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                // Power-of-two depth: pointers wrap naturally.
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            // Set beats clear when both happen together.
            if (drop)
                overrun_q <= 1'b1;
            else if (overrun_clr_i)
                overrun_q <= 1'b0;
        end
    end

    // Storage is not reset; contents are only visible while valid_o is high.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i)
            mem_q[wr_ptr_q] <= rx_data_i;
    end

    assign data_o       = valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign count_o      = count_q;
    assign overrun_o    = overrun_q;
    assign thresh_irq_o = (threshold_i != '0) && (count_q >= threshold_i);

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int TickW = (BitTicks > 1) ? $clog2(BitTicks) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TIMEOUT
    } to_state_e;

    to_state_e        state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [7:0]       bit_q, bit_d;
    logic [8:0]       bit_inc;

    assign bit_inc = {1'b0, bit_q} + 9'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        if (flush_i || count_d == '0) begin
            state_d = ST_IDLE;
            tick_d  = '0;
            bit_d   = '0;
        end else if (push || pop) begin
            state_d = ST_WAIT;
            tick_d  = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    tick_d  = '0;
                    bit_d   = '0;
                end
                ST_WAIT: begin
                    if (tick_q == TickW'(BitTicks - 1)) begin
                        tick_d = '0;
                        // Saturate so a disabled timeout never wraps around.
                        bit_d  = bit_inc[8] ? 8'hFF : bit_inc[7:0];
                        // Compare only on increment with >=, so lowering the
                        // limit below the current count fires at the next bit
                        // instead of retroactively.
                        if (timeout_bits_i != 8'd0 && bit_inc >= {1'b0, timeout_bits_i})
                            state_d = ST_TIMEOUT;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_TIMEOUT: state_d = ST_TIMEOUT;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    assign timeout_irq_o = (state_q == ST_TIMEOUT);
`else
    logic unused_timeout_bits;
    assign unused_timeout_bits = ^timeout_bits_i;
    assign timeout_irq_o       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    localparam int CntW = 5;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            rx_en_i;
    logic            flush_i;
    logic [7:0]      rx_data_i;
    logic            rx_valid_i;
    logic [7:0]      data_o;
    logic            valid_o;
    logic            ready_i;
    logic [CntW-1:0] count_o;
    logic [CntW-1:0] threshold_i;
    logic            thresh_irq_o;
    logic            overrun_o;
    logic            overrun_clr_i;
    logic [7:0]      timeout_bits_i;
    logic            timeout_irq_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    uart_rx_ctrl #(.FifoDepth(16), .BitTicks(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_en_i(rx_en_i), .flush_i(flush_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o),
        .threshold_i(threshold_i), .thresh_irq_o(thresh_irq_o),
        .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i),
        .timeout_bits_i(timeout_bits_i), .timeout_irq_o(timeout_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        if (accept) exp_q.push_back(b);
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic pop_n(input int n);
        ready_i = 1'b1;
        repeat (n) tick();
        ready_i = 1'b0;
    endtask

    // Monitor: every handshake on the output is checked against the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop got=%0h expected=none", data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", {24'd0, data_o}, {24'd0, mon_exp});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; rx_en_i = 1'b1; flush_i = 1'b0; rx_data_i = '0;
        rx_valid_i = 1'b0; ready_i = 1'b0; threshold_i = '0;
        overrun_clr_i = 1'b0; timeout_bits_i = '0;
        tick(); tick();
        rst_i = 1'b0;

        // Reset state
        chk("rst_count", count_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_thresh", thresh_irq_o, 0);
        chk("rst_timeout", timeout_irq_o, 0);

        // Basic push then drain
        push(8'h11, 1); chk("basic_cnt1", count_o, 1);
        chk("basic_head", data_o, 8'h11);
        push(8'h22, 1); chk("basic_cnt2", count_o, 2);
        push(8'h33, 1); chk("basic_cnt3", count_o, 3);
        pop_n(3);
        chk("basic_cnt0", count_o, 0);
        chk("basic_valid0", valid_o, 0);

        // Threshold interrupt
        threshold_i = 5'd4;
        for (int i = 0; i < 3; i++) begin
            push(8'h60 + 8'(i), 1);
            chk("thr_below", thresh_irq_o, 0);
        end
        push(8'h63, 1);
        chk("thr_at", thresh_irq_o, 1);
        pop_n(1);
        chk("thr_after_pop", thresh_irq_o, 0);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        exp_q.delete();
        threshold_i = '0;
        chk("thr_flush_cnt", count_o, 0);

        // Overrun: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) push(8'h40 + 8'(i), i < 16);
        chk("ovr_count", count_o, 16);
        chk("ovr_flag", overrun_o, 1);
        // Push with simultaneous pop while full
        ready_i = 1'b1;
        push(8'hA5, 1);
        ready_i = 1'b0;
        chk("full_pop_cnt", count_o, 16);
        overrun_clr_i = 1'b1; tick(); overrun_clr_i = 1'b0;
        chk("ovr_clr", overrun_o, 0);
        // Drop and clear together: set wins
        overrun_clr_i = 1'b1;
        push(8'hEE, 0);
        overrun_clr_i = 1'b0;
        chk("ovr_set_wins", overrun_o, 1);
        chk("ovr_drop_cnt", count_o, 16);
        overrun_clr_i = 1'b1; tick(); overrun_clr_i = 1'b0;
        pop_n(16);
        chk("ovr_drained", count_o, 0);

        // Flush with push and pop in the same cycle
        for (int i = 0; i < 5; i++) push(8'h70 + 8'(i), 1);
        chk("fl_pre_cnt", count_o, 5);
        flush_i = 1'b1; rx_data_i = 8'h77; rx_valid_i = 1'b1; ready_i = 1'b1;
        tick();
        flush_i = 1'b0; rx_valid_i = 1'b0; ready_i = 1'b0;
        exp_q.delete();
        chk("fl_count", count_o, 0);
        chk("fl_valid", valid_o, 0);
        chk("fl_overrun", overrun_o, 0);
        rx_en_i = 1'b0;
        push(8'h99, 0);
        rx_en_i = 1'b1;
        chk("dis_count", count_o, 0);
        chk("dis_overrun", overrun_o, 0);

`ifdef UART_RX_CTRL_TIMEOUT_EN
        timeout_bits_i = 8'd4;
        push(8'h5A, 1);
        repeat (31) tick();
        chk("to_before", timeout_irq_o, 0);
        tick();
        chk("to_rise", timeout_irq_o, 1);
        pop_n(1);
        chk("to_clear", timeout_irq_o, 0);
        repeat (40) tick();
        chk("to_idle", timeout_irq_o, 0);
        timeout_bits_i = 8'd0;
        push(8'h5B, 1);
        repeat (60) tick();
        chk("to_disabled", timeout_irq_o, 0);
        pop_n(1);
`else
        timeout_bits_i = 8'd4;
        push(8'h5A, 1);
        repeat (40) tick();
        chk("to_absent", timeout_irq_o, 0);
        pop_n(1);
`endif
        timeout_bits_i = '0;

        // Reset mid-operation
        threshold_i = 5'd4;
        for (int i = 0; i < 17; i++) push(8'h80 + 8'(i), i < 16);
        pop_n(9);
        chk("mid_count", count_o, 7);
        chk("mid_overrun", overrun_o, 1);
        chk("mid_thresh", thresh_irq_o, 1);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        exp_q.delete();
        chk("mr_count", count_o, 0);
        chk("mr_valid", valid_o, 0);
        chk("mr_data", data_o, 0);
        chk("mr_overrun", overrun_o, 0);
        chk("mr_thresh", thresh_irq_o, 0);
        chk("mr_timeout", timeout_irq_o, 0);
        push(8'hC3, 1);
        chk("mr_push_cnt", count_o, 1);
        pop_n(1);
        chk("mr_final_cnt", count_o, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller placed between `uart_rx` and the APB register block. It accepts byte pulses from the receiver and buffers them in a first-word-fall-through FIFO that is drained over a valid/ready handshake. It also gates reception with an enable, flags overruns, raises a fill-level interrupt and, optionally, a character-timeout interrupt.

## Interface
- `FifoDepth`, 16: FIFO entries; power of two, ≥ 2.
- `BitTicks`, 8: clk cycles per UART bit. Must equal the `uart_rx` setting.
- `CntW`, `$clog2(FifoDepth)+1`: width of the count and threshold fields (localparam).
- `clk_i` in 1: sole clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `rx_en_i` in 1: receive enable. When 0, incoming bytes are discarded.
- `flush_i` in 1: one-cycle FIFO clear.
- `rx_data_i` in 8: byte from `uart_rx.data_o`.
- `rx_valid_i` in 1: one-cycle pulse from `uart_rx.data_valid_o`.
- `data_o` out 8: head-of-FIFO byte.
- `valid_o` out 1: FIFO non-empty.
- `ready_i` in 1: consumer pops when `valid_o && ready_i`.
- `count_o` out CntW: current fill level, 0..FifoDepth.
- `threshold_i` in CntW: fill-interrupt level; 0 disables.
- `thresh_irq_o` out 1: level interrupt, asserted while `count_o >= threshold_i` and `threshold_i != 0`.
- `overrun_o` out 1: sticky; set when a byte is dropped because the FIFO is full.
- `overrun_clr_i` in 1: clears `overrun_o`.
- `timeout_bits_i` in 8: character timeout in bit periods; 0 disables.
- `timeout_irq_o` out 1: level interrupt for character timeout.

## Operation
- Reset values: `count_o`=0, `valid_o`=0, `data_o`=0, `overrun_o`=0, `thresh_irq_o`=0, `timeout_irq_o`=0. Read/write pointers are 0 and the timeout FSM is in IDLE.
- Push: occurs when `rx_valid_i && rx_en_i && (count_o<FifoDepth || pop)`. The byte is written at the write pointer.
- Pop: occurs when `valid_o && ready_i`. The read pointer advances.
- Pointers wrap modulo FifoDepth.
- Full and pop in the same cycle: the push is accepted and the count is unchanged.
- Empty with a push: no pop is possible that cycle.
- Overrun: a push attempt while full without a pop drops the byte and sets `overrun_o`. If set and `overrun_clr_i` occur in the same cycle, set wins.
- `rx_valid_i` with `rx_en_i`=0: the byte is ignored and the overrun flag is not affected.
- Flush: has priority over push and pop in the same cycle. Pointers and count go to 0, and the timeout FSM goes to IDLE. Flush does not clear `overrun_o`.
- `data_o` reflects `mem[rd_ptr]` whenever `valid_o`=1; its value is don't-care when empty.
- Timeout FSM:
  - IDLE (FIFO empty): no counting.
  - WAIT (FIFO non-empty): the tick counter runs 0..BitTicks-1; each wrap increments the bit counter. Any push, pop or flush clears both counters.
  - WAIT → TIMEOUT when the bit counter equals `timeout_bits_i` and `timeout_bits_i != 0`.
  - TIMEOUT asserts `timeout_irq_o`. Push or pop → WAIT with counters cleared, or → IDLE if the FIFO becomes empty. Flush → IDLE.
  - Any state → IDLE when the count becomes 0.
- Changing `timeout_bits_i` mid-count takes effect on the next compare. A value at or below the current bit count fires on the next bit-counter increment; it does not fire retroactively.

## Timing
- Push accepted at edge N: `valid_o`, `count_o`, `data_o` and `thresh_irq_o` are updated after edge N. The consumer sees the byte in the cycle after `rx_valid_i`.
- Pop at edge N: the next entry is on `data_o` after edge N. Back-to-back pops run at 1 per cycle.
- `thresh_irq_o` is combinational from the `count_o` register and `threshold_i`, so it tracks `count_o` in the same cycle.
- Timeout: with no push or pop after edge E, `timeout_irq_o` rises after edge E + `timeout_bits_i`·BitTicks and falls after the edge of the next push, pop or flush.
- Reset asserted mid-operation: all state returns to reset values at the next edge; stored bytes are lost.

## Configuration
- `UART_RX_CTRL_TIMEOUT_EN` defined: the timeout counters and FSM are built and behave as above.
- Macro undefined: the timeout logic is removed, `timeout_irq_o` is tied to 0 and `timeout_bits_i` is ignored. FIFO, overrun and threshold behaviour are unchanged.

## Test plan
- Push 0x11, 0x22, 0x33 with `ready_i`=0, then hold `ready_i`=1 → `count_o` 1,2,3 after each push, then `data_o` 0x11, 0x22, 0x33 on consecutive cycles and `count_o` back to 0.
- FifoDepth=16: push 17 bytes without popping → `count_o`=16, `overrun_o`=1, 17th byte absent. Next, push with a simultaneous pop while full → byte accepted, count stays 16. Pulse `overrun_clr_i` → `overrun_o`=0.
- `threshold_i`=4: push 3 bytes → `thresh_irq_o`=0; 4th push → `thresh_irq_o`=1 in the cycle after; one pop → `thresh_irq_o`=0.
- With the macro defined, `timeout_bits_i`=4 and BitTicks=8: push one byte and stay idle → `timeout_irq_o` rises exactly 32 cycles after the push edge; a pop clears it and the empty FIFO stays in IDLE with no further irq. Repeat with `timeout_bits_i`=0 → irq never asserts.
- Same-cycle flush + push + pop with count 5 → count 0, `valid_o`=0, `overrun_o` unchanged. Then `rx_en_i`=0 with a `rx_valid_i` pulse → count stays 0.
- Assert `rst_i` with count 7 and `overrun_o`=1 → all outputs 0 after one edge; a subsequent push works normally.
